fetch_stage: RTL

Instruction-fetch stage of the LC-3b pipeline: owns the PC and the instruction-memory read handshake, and writes the IF/ID pipeline register. It consumes the stall, flush and redirect controls from hazard detection, and returns to it the fetched opcode/nzp and the fetch address used for branch prediction. Redirect targets come from WB; predicted-taken targets are computed here.

---
 rtl/fetch_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b instruction-fetch stage.
// Owns the PC, drives the instruction-memory read handshake and writes the
// IF/ID pipeline register. Optional static branch prediction is enabled by
// defining FETCH_PREDICT_EN; without it, fetch is always predict-not-taken.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        prediction,
  output logic [15:0] i_mem_address,
  output logic        i_mem_read,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_resp,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_npc,
  output logic [3:0]  op_IF,
  output logic [2:0]  nzp_IF
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] target_reg, target_next;
  logic [15:0] hold_reg, hold_next;
  logic        if_valid_reg, if_valid_next;
  logic [15:0] if_instr_reg, if_instr_next;
  logic [15:0] if_pc_reg, if_pc_next;
  logic [15:0] if_npc_reg, if_npc_next;

  logic        word_avail;
  logic [15:0] fetch_word;
  logic [15:0] pc_plus2;
  logic [15:0] next_pc;

  // The word being retired is the buffered one in HOLD, otherwise the live bus.
  assign fetch_word = (state_reg == HOLD) ? hold_reg : i_mem_rdata;
  assign pc_plus2   = pc_reg + 16'd2;

`ifdef FETCH_PREDICT_EN
  logic        is_cond_br;
  logic [15:0] br_offset;

  // Conditional branch: opcode 0000 with at least one nzp bit set.
  assign is_cond_br = (fetch_word[15:12] == 4'b0000) && (fetch_word[11:9] != 3'b000);
  assign br_offset  = {{6{fetch_word[8]}}, fetch_word[8:0], 1'b0};
  assign next_pc    = (is_cond_br && prediction) ? (pc_plus2 + br_offset) : pc_plus2;
`else
  logic unused_prediction;

  assign unused_prediction = prediction;
  assign next_pc           = pc_plus2;
`endif

  assign i_mem_address = pc_reg;
  assign i_mem_read    = (state_reg == REQ) || (state_reg == SQUASH);
  assign if_valid      = if_valid_reg;
  assign if_instr      = if_instr_reg;
  assign if_pc         = if_pc_reg;
  assign if_npc        = if_npc_reg;
  assign op_IF         = if_instr_reg[15:12];
  assign nzp_IF        = if_instr_reg[11:9];

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, PC/target/hold updates and IF/ID next values.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    target_next   = target_reg;
    hold_next     = hold_reg;
    word_avail    = 1'b0;
    if_valid_next = if_valid_reg;
    if_instr_next = if_instr_reg;
    if_pc_next    = if_pc_reg;
    if_npc_next   = if_npc_reg;

    case (state_reg)
      IDLE: begin
        // Late responses are ignored here; a redirect just moves the PC.
        if (redirect) pc_next = redirect_target;
        if (fetch_en) state_next = REQ;
      end
      REQ: begin
        if (!i_mem_resp) begin
          // The address must not move while the request is outstanding,
          // so the new target waits in target_reg until the response.
          if (redirect) begin
            target_next = redirect_target;
            state_next  = SQUASH;
          end else if (flush) begin
            target_next = pc_reg;
            state_next  = SQUASH;
          end
        end else if (redirect) begin
          pc_next    = redirect_target;
          state_next = fetch_en ? REQ : IDLE;
        end else if (flush) begin
          // Word discarded; refetch from the same PC.
          state_next = fetch_en ? REQ : IDLE;
        end else if (load) begin
          word_avail = 1'b1;
          pc_next    = next_pc;
          state_next = fetch_en ? REQ : IDLE;
        end else begin
          hold_next  = i_mem_rdata;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          hold_next  = 16'h0000;
          pc_next    = redirect_target;
          state_next = IDLE;
        end else if (flush) begin
          hold_next  = 16'h0000;
          state_next = IDLE;
        end else if (load) begin
          word_avail = 1'b1;
          hold_next  = 16'h0000;
          pc_next    = next_pc;
          state_next = fetch_en ? REQ : IDLE;
        end
      end
      SQUASH: begin
        if (redirect) target_next = redirect_target;
        if (i_mem_resp) begin
          pc_next    = redirect ? redirect_target : target_reg;
          state_next = fetch_en ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // IF/ID: flush wins, load with no word is a bubble, otherwise hold.
    if (flush) begin
      if_valid_next = 1'b0;
    end else if (load) begin
      if (word_avail) begin
        if_valid_next = 1'b1;
        if_instr_next = fetch_word;
        if_pc_next    = pc_reg;
        if_npc_next   = pc_plus2;
      end else begin
        if_valid_next = 1'b0;
      end
    end
  end

  // Datapath registers: PC, squash target, hold buffer and IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      target_reg   <= 16'h0000;
      hold_reg     <= 16'h0000;
      if_valid_reg <= 1'b0;
      if_instr_reg <= 16'h0000;
      if_pc_reg    <= 16'h0000;
      if_npc_reg   <= 16'h0000;
    end else begin
      pc_reg       <= pc_next;
      target_reg   <= target_next;
      hold_reg     <= hold_next;
      if_valid_reg <= if_valid_next;
      if_instr_reg <= if_instr_next;
      if_pc_reg    <= if_pc_next;
      if_npc_reg   <= if_npc_next;
    end
  end

endmodule
